// File: rtl/hwpe_ctrl_bist_package.sv
// Shared types and per-element constants for the March C- register file BIST.
package hwpe_ctrl_bist_package;

    // March C- elements in execution order
    typedef enum logic [2:0] {
        M0 = 3'd0,
        M1 = 3'd1,
        M2 = 3'd2,
        M3 = 3'd3,
        M4 = 3'd4,
        M5 = 3'd5
    } march_elem_e;

    // Operation kind inside an element
    typedef enum logic {
        OP_R = 1'b0,
        OP_W = 1'b1
    } march_op_e;

    // Sequencer states
    typedef enum logic [1:0] {
        BIST_IDLE  = 2'd0,
        BIST_RUN   = 2'd1,
        BIST_DRAIN = 2'd2,
        BIST_DONE  = 2'd3
    } bist_state_e;

    // One bit per element, indexed by the element code (bits 6/7 unused).
    // Address walks downward for M3..M5.
    localparam logic [7:0] ELEM_DOWN    = 8'b0011_1000;
    // Elements with a read followed by a write (M1..M4); M0 and M5 have one op.
    localparam logic [7:0] ELEM_TWO_OPS = 8'b0001_1110;
    // Read expects ~P in M2 and M4, P elsewhere.
    localparam logic [7:0] ELEM_RD_POL  = 8'b0001_0100;
    // Write stores ~P in M1 and M3, P elsewhere.
    localparam logic [7:0] ELEM_WR_POL  = 8'b0000_1010;

    // M0 is a lone write; all other elements start with a read and, when they
    // have a second op, it is the write.
    function automatic march_op_e elem_op(input march_elem_e elem, input logic op_idx);
        march_op_e op;
        if (elem == M0) begin
            op = OP_W;
        end else if (op_idx) begin
            op = OP_W;
        end else begin
            op = OP_R;
        end
        return op;
    endfunction

endpackage

// File: rtl/hwpe_ctrl_bist_checker.sv
// Read-compare pipeline: delays expected data to line up with rdata_i, flags
// mismatches, captures the first failure and counts errors (saturating).
module hwpe_ctrl_bist_checker
    import hwpe_ctrl_bist_package::*;
#(
    parameter int unsigned ADDR_WIDTH    = 5,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned READ_LATENCY  = 1,
    parameter int unsigned ERR_CNT_WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clr_i,
    input  logic                     push_i,
    input  logic [DATA_WIDTH-1:0]    exp_i,
    input  logic [ADDR_WIDTH-1:0]    addr_i,
    input  logic [2:0]               elem_i,
    input  logic [DATA_WIDTH-1:0]    rdata_i,
    output logic                     fail_o,
    output logic [ADDR_WIDTH-1:0]    fail_addr_o,
    output logic [2:0]               fail_elem_o,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt_o
);

    logic [READ_LATENCY-1:0] r_vld;
    logic [DATA_WIDTH-1:0]   r_exp  [READ_LATENCY];
    logic [ADDR_WIDTH-1:0]   r_addr [READ_LATENCY];
    logic [2:0]              r_elem [READ_LATENCY];

    logic                     r_fail;
    logic [ADDR_WIDTH-1:0]    r_fail_addr;
    logic [2:0]               r_fail_elem;
    logic [ERR_CNT_WIDTH-1:0] r_err_cnt;

    logic w_mismatch;

    // Valid bits of the compare pipe; a clear flushes in-flight reads
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_vld <= '0;
        end else if (clr_i) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= push_i;
            for (int i = 1; i < int'(READ_LATENCY); i++) begin
                r_vld[i] <= r_vld[i-1];
            end
        end
    end

    // Payload of the compare pipe; only meaningful where the valid bit is set
    always_ff @(posedge clk_i) begin
        r_exp[0]  <= exp_i;
        r_addr[0] <= addr_i;
        r_elem[0] <= elem_i;
        for (int i = 1; i < int'(READ_LATENCY); i++) begin
            r_exp[i]  <= r_exp[i-1];
            r_addr[i] <= r_addr[i-1];
            r_elem[i] <= r_elem[i-1];
        end
    end

    // Compare the popped entry against the data returned by the regfile
    always_comb begin
        w_mismatch = r_vld[READ_LATENCY-1] && (rdata_i != r_exp[READ_LATENCY-1]);
    end

    // Sticky first-fail capture and saturating error counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_elem <= '0;
            r_err_cnt   <= '0;
        end else if (clr_i) begin
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_elem <= '0;
            r_err_cnt   <= '0;
        end else if (w_mismatch) begin
            if (r_err_cnt != '1) begin
                r_err_cnt <= r_err_cnt + ERR_CNT_WIDTH'(1);
            end
            if (!r_fail) begin
                r_fail      <= 1'b1;
                r_fail_addr <= r_addr[READ_LATENCY-1];
                r_fail_elem <= r_elem[READ_LATENCY-1];
            end
        end
    end

    assign fail_o      = r_fail;
    assign fail_addr_o = r_fail_addr;
    assign fail_elem_o = r_fail_elem;
    assign err_cnt_o   = r_err_cnt;

endmodule

// File: rtl/hwpe_ctrl_regfile_bist.sv
// March C- BIST sequencer for the HWPE control register file test port.
// Drives one operation per cycle through M0..M5, then drains the read pipe.
module hwpe_ctrl_regfile_bist
    import hwpe_ctrl_bist_package::*;
#(
    parameter int unsigned ADDR_WIDTH    = 5,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned READ_LATENCY  = 1,
    parameter int unsigned ERR_CNT_WIDTH = 8,
    localparam int unsigned NUM_BYTE     = DATA_WIDTH / 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic                     start_i,
    input  logic [DATA_WIDTH-1:0]    pattern_i,
    output logic                     bist_o,
    output logic                     csn_o,
    output logic                     wen_o,
    output logic [ADDR_WIDTH-1:0]    addr_o,
    output logic [DATA_WIDTH-1:0]    wdata_o,
    output logic [NUM_BYTE-1:0]      be_o,
    input  logic [DATA_WIDTH-1:0]    rdata_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     fail_o,
    output logic [ADDR_WIDTH-1:0]    fail_addr_o,
    output logic [2:0]               fail_elem_o,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt_o
);

    bist_state_e             r_state,  w_state;
    march_elem_e             r_elem,   w_elem;
    logic [ADDR_WIDTH-1:0]   r_addr,   w_addr;
    logic                    r_op_idx, w_op_idx;
    logic [1:0]              r_drain,  w_drain;
    logic [DATA_WIDTH-1:0]   r_pattern;

    march_op_e               w_op;
    logic                    w_run;
    logic                    w_last_addr;
    logic                    w_start_acc;
    logic                    w_chk_clr;
    logic                    w_push;
    logic [DATA_WIDTH-1:0]   w_exp;

    // Sequencer state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= BIST_IDLE;
            r_elem   <= M0;
            r_addr   <= '0;
            r_op_idx <= 1'b0;
            r_drain  <= '0;
        end else begin
            r_state  <= w_state;
            r_elem   <= w_elem;
            r_addr   <= w_addr;
            r_op_idx <= w_op_idx;
            r_drain  <= w_drain;
        end
    end

    // Background pattern, captured only when a run is accepted
    always_ff @(posedge clk_i) begin
        if (w_start_acc) begin
            r_pattern <= pattern_i;
        end
    end

    // Next-state logic: op index, then address, then element advance
    always_comb begin
        w_state     = r_state;
        w_elem      = r_elem;
        w_addr      = r_addr;
        w_op_idx    = r_op_idx;
        w_drain     = r_drain;
        w_start_acc = 1'b0;
        w_op        = elem_op(r_elem, r_op_idx);
        w_last_addr = ELEM_DOWN[r_elem] ? (r_addr == '0) : (r_addr == '1);

        case (r_state)
            BIST_IDLE, BIST_DONE: begin
                if (start_i) begin
                    w_start_acc = 1'b1;
                    w_state     = BIST_RUN;
                    w_elem      = M0;
                    w_addr      = '0;
                    w_op_idx    = 1'b0;
                end
            end
            BIST_RUN: begin
                if (ELEM_TWO_OPS[r_elem] && !r_op_idx) begin
                    w_op_idx = 1'b1;
                end else begin
                    w_op_idx = 1'b0;
                    if (w_last_addr) begin
                        if (r_elem == M5) begin
                            w_state = BIST_DRAIN;
                            w_drain = '0;
                        end else begin
                            w_elem = march_elem_e'(r_elem + 3'd1);
                            w_addr = ELEM_DOWN[r_elem + 3'd1] ? '1 : '0;
                        end
                    end else if (ELEM_DOWN[r_elem]) begin
                        w_addr = r_addr - ADDR_WIDTH'(1);
                    end else begin
                        w_addr = r_addr + ADDR_WIDTH'(1);
                    end
                end
            end
            BIST_DRAIN: begin
                if (r_drain == 2'(READ_LATENCY - 1)) begin
                    w_state = BIST_DONE;
                end else begin
                    w_drain = r_drain + 2'd1;
                end
            end
            default: begin
                w_state = BIST_IDLE;
            end
        endcase

        if (clear_i) begin
            w_state     = BIST_IDLE;
            w_start_acc = 1'b0;
        end
    end

    // Test-port drive and status decode from the registered state
    always_comb begin
        w_run   = (r_state == BIST_RUN);
        bist_o  = w_run || (r_state == BIST_DRAIN);
        busy_o  = bist_o;
        done_o  = (r_state == BIST_DONE);
        csn_o   = !w_run;
        wen_o   = !(w_run && (w_op == OP_W));
        addr_o  = w_run ? r_addr : '0;
        wdata_o = '0;
        if (w_run && (w_op == OP_W)) begin
            wdata_o = ELEM_WR_POL[r_elem] ? ~r_pattern : r_pattern;
        end
        be_o    = '1;
        w_push  = w_run && (w_op == OP_R);
        w_exp   = ELEM_RD_POL[r_elem] ? ~r_pattern : r_pattern;
        w_chk_clr = clear_i || w_start_acc;
    end

    hwpe_ctrl_bist_checker #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH),
        .READ_LATENCY  (READ_LATENCY),
        .ERR_CNT_WIDTH (ERR_CNT_WIDTH)
    ) i_checker (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clr_i       (w_chk_clr),
        .push_i      (w_push),
        .exp_i       (w_exp),
        .addr_i      (r_addr),
        .elem_i      (r_elem),
        .rdata_i     (rdata_i),
        .fail_o      (fail_o),
        .fail_addr_o (fail_addr_o),
        .fail_elem_o (fail_elem_o),
        .err_cnt_o   (err_cnt_o)
    );

endmodule
